// File: rtl/wb_decomp_param.sv
// Bridge from the narrow cw link to a single-cycle Wishbone master.
// Optional Wishbone timeout is compiled in with WB_DECOMP_TIMEOUT_EN.
module wb_decomp_param #(
  parameter int CW_W        = 16,
  parameter int WB_DATA_W   = 16,
  parameter int WB_ADDR_W   = 24,
  parameter int WB_SEL_BITS = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CW_W-1:0]        cw_io_i,
  output logic [CW_W-1:0]        cw_io_o,
  input  logic                   cw_req,
  input  logic                   cw_dir,
  output logic                   cw_ack,
  output logic                   cw_err,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [WB_ADDR_W-1:0]   wb_adr,
  output logic [WB_SEL_BITS-1:0] wb_sel,
  output logic [WB_DATA_W-1:0]   wb_o_dat,
  input  logic [WB_DATA_W-1:0]   wb_i_dat,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  output logic                   o_busy
);
  localparam int HDR_W      = WB_SEL_BITS + WB_ADDR_W;
  localparam int HDR_BEATS  = (HDR_W + CW_W - 1) / CW_W;
  localparam int DAT_BEATS  = (WB_DATA_W + CW_W - 1) / CW_W;
  localparam int HDR_BUS_W  = HDR_BEATS * CW_W;
  localparam int DAT_BUS_W  = DAT_BEATS * CW_W;
  localparam int MAX_BEATS  = (HDR_BEATS > DAT_BEATS) ? HDR_BEATS : DAT_BEATS;
  localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [2:0] {IDLE, HDR, WDAT, WB, RESP} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dir_q;
  logic                   resp_data_q;
  logic [HDR_BUS_W-1:0]   hdr_q, hdr_d;
  logic [DAT_BUS_W-1:0]   wdat_q, wdat_d;
  logic [DAT_BUS_W-1:0]   rdat_q, rdat_ext;
  logic [CW_W-1:0]        cw_io_q;
  logic                   cw_ack_q, cw_err_q, cyc_q, we_q;
  logic [WB_ADDR_W-1:0]   adr_q;
  logic [WB_SEL_BITS-1:0] sel_q;
  logic [WB_DATA_W-1:0]   odat_q;
  logic                   hdr_last, dat_last, dir_now, go_wb, to_hit, wb_fail;

`ifdef WB_DECOMP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q;
  assign to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
  // Without the timeout the limit has no effect; keep it referenced.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign to_hit = 1'b0;
`endif

  // Beats arrive LSB-first: shift right and insert each new beat at the top.
  always_comb begin
    hdr_d = hdr_q;
    if ((state_q == IDLE && cw_req) || state_q == HDR)
      hdr_d = (hdr_q >> CW_W) | (HDR_BUS_W'(cw_io_i) << (HDR_BUS_W - CW_W));
    wdat_d = wdat_q;
    if (state_q == WDAT)
      wdat_d = (wdat_q >> CW_W) | (DAT_BUS_W'(cw_io_i) << (DAT_BUS_W - CW_W));
    rdat_ext = DAT_BUS_W'(wb_i_dat);
    hdr_last = (state_q == IDLE) ? (HDR_BEATS == 1) : (cnt_q == CNT_W'(HDR_BEATS - 1));
    dat_last = (cnt_q == CNT_W'(DAT_BEATS - 1));
    dir_now  = (state_q == IDLE) ? cw_dir : dir_q;
    go_wb    = ((state_q == IDLE && cw_req) || state_q == HDR) && hdr_last && !dir_now
               || (state_q == WDAT && dat_last);
    wb_fail  = wb_err | to_hit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      resp_data_q <= 1'b0;
      hdr_q       <= '0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      cw_io_q     <= '0;
      cw_ack_q    <= 1'b0;
      cw_err_q    <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      odat_q      <= '0;
`ifdef WB_DECOMP_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      hdr_q  <= hdr_d;
      wdat_q <= wdat_d;
      if (go_wb) begin
        cyc_q  <= 1'b1;
        we_q   <= dir_now;
        adr_q  <= hdr_d[WB_ADDR_W-1:0];
        sel_q  <= hdr_d[HDR_W-1:WB_ADDR_W];
        odat_q <= dir_now ? wdat_d[WB_DATA_W-1:0] : '0;
`ifdef WB_DECOMP_TIMEOUT_EN
        to_q   <= '0;
`endif
      end
      case (state_q)
        IDLE: if (cw_req) begin
          dir_q <= cw_dir;
          if (hdr_last) begin
            cnt_q   <= '0;
            state_q <= cw_dir ? WDAT : WB;
          end else begin
            cnt_q   <= CNT_W'(1);
            state_q <= HDR;
          end
        end
        HDR: if (hdr_last) begin
          cnt_q   <= '0;
          state_q <= dir_q ? WDAT : WB;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        WDAT: if (dat_last) begin
          cnt_q   <= '0;
          state_q <= WB;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        WB: if (wb_ack || wb_fail) begin
          cyc_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RESP;
          if (wb_fail) begin
            cw_err_q <= 1'b1;
          end else begin
            cw_ack_q <= 1'b1;
            if (!we_q) begin
              resp_data_q <= 1'b1;
              cw_io_q     <= rdat_ext[CW_W-1:0];
              rdat_q      <= rdat_ext >> CW_W;
            end
          end
        end else begin
`ifdef WB_DECOMP_TIMEOUT_EN
          to_q <= to_q + 1'b1;
`endif
        end
        RESP: begin
          cw_ack_q <= 1'b0;
          cw_err_q <= 1'b0;
          if (!resp_data_q || dat_last) begin
            state_q     <= IDLE;
            cw_io_q     <= '0;
            resp_data_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            cw_io_q <= rdat_q[CW_W-1:0];
            rdat_q  <= rdat_q >> CW_W;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cw_io_o  = cw_io_q;
  assign cw_ack   = cw_ack_q;
  assign cw_err   = cw_err_q;
  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_adr   = adr_q;
  assign wb_sel   = sel_q;
  assign wb_o_dat = odat_q;
  assign o_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_wb_decomp_param.sv
// Directed bench for wb_decomp_param with an 8-bit link, 16-bit data, 24-bit address.
module tb_wb_decomp_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cw_io_i, cw_io_o;
  logic        cw_req, cw_dir, cw_ack, cw_err;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, o_busy;
  logic [23:0] wb_adr;
  logic [1:0]  wb_sel;
  logic [15:0] wb_o_dat, wb_i_dat;
  int          nchecks = 0;
  int          nerrors = 0;
  int          stb_starts = 0;
  logic        stb_prev = 1'b0;

  wb_decomp_param #(.CW_W(8), .WB_DATA_W(16), .WB_ADDR_W(24), .WB_SEL_BITS(2), .TIMEOUT_CYC(4)) dut (
    .i_clk(clk), .i_rst(rst), .cw_io_i(cw_io_i), .cw_io_o(cw_io_o), .cw_req(cw_req),
    .cw_dir(cw_dir), .cw_ack(cw_ack), .cw_err(cw_err), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_o_dat(wb_o_dat), .wb_i_dat(wb_i_dat),
    .wb_ack(wb_ack), .wb_err(wb_err), .o_busy(o_busy));

  always #5 clk = ~clk;

  // Count Wishbone cycle starts, sampled away from the active edge.
  always @(negedge clk) begin
    if (wb_stb && !stb_prev) stb_starts++;
    stb_prev = wb_stb;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic req, input logic dir, input logic [7:0] b);
    cw_req = req; cw_dir = dir; cw_io_i = b;
    tick();
    cw_req = 1'b0; cw_io_i = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1; cw_req = 0; cw_dir = 0; cw_io_i = 0; wb_ack = 0; wb_err = 0; wb_i_dat = 0;
    #1;
    nchecks++; if ({wb_cyc, wb_stb, wb_we, cw_ack, cw_err, o_busy} !== 6'b0) begin nerrors++; $display("FAIL rst_ctrl: got %b exp 000000", {wb_cyc, wb_stb, wb_we, cw_ack, cw_err, o_busy}); end
    nchecks++; if ({wb_adr, wb_sel, wb_o_dat, cw_io_o} !== 50'd0) begin nerrors++; $display("FAIL rst_data: got %h exp 0", {wb_adr, wb_sel, wb_o_dat, cw_io_o}); end
    tick(); tick();
    rst = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_write;
    int starts0 = stb_starts;
    beat(1, 1, 8'h34); beat(0, 0, 8'h12); beat(0, 0, 8'h00); beat(0, 0, 8'h03);
    beat(0, 0, 8'hEF); beat(0, 0, 8'hBE);
    nchecks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b111) begin nerrors++; $display("FAIL wr_ctl: got %b exp 111", {wb_cyc, wb_stb, wb_we}); end
    nchecks++; if (wb_adr !== 24'h001234) begin nerrors++; $display("FAIL wr_adr: got %h exp 001234", wb_adr); end
    nchecks++; if (wb_sel !== 2'd3) begin nerrors++; $display("FAIL wr_sel: got %h exp 3", wb_sel); end
    nchecks++; if (wb_o_dat !== 16'hBEEF) begin nerrors++; $display("FAIL wr_dat: got %h exp beef", wb_o_dat); end
    tick();
    nchecks++; if ({wb_stb, cw_ack} !== 2'b10) begin nerrors++; $display("FAIL wr_hold: got %b exp 10", {wb_stb, cw_ack}); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    nchecks++; if ({wb_stb, cw_ack, cw_err, o_busy} !== 4'b0101) begin nerrors++; $display("FAIL wr_resp: got %b exp 0101", {wb_stb, cw_ack, cw_err, o_busy}); end
    nchecks++; if (cw_io_o !== 8'h00) begin nerrors++; $display("FAIL wr_io: got %h exp 00", cw_io_o); end
    tick();
    nchecks++; if ({cw_ack, o_busy} !== 2'b00) begin nerrors++; $display("FAIL wr_end: got %b exp 00", {cw_ack, o_busy}); end
    nchecks++; if (stb_starts - starts0 !== 1) begin nerrors++; $display("FAIL wr_ncyc: got %0d exp 1", stb_starts - starts0); end
    $display("txn write adr=001234 sel=3 dat=beef");
  endtask

  // Read 008000/sel=1 answered with A55A in the first stb cycle; ends in the first IDLE cycle.
  task automatic read_a55a(input string tag);
    beat(1, 0, 8'h00); beat(0, 0, 8'h80); beat(0, 0, 8'h00); beat(0, 0, 8'h01);
    nchecks++; if ({wb_stb, wb_we} !== 2'b10) begin nerrors++; $display("FAIL %s_stb: got %b exp 10", tag, {wb_stb, wb_we}); end
    nchecks++; if ({wb_sel, wb_adr} !== 26'h1008000) begin nerrors++; $display("FAIL %s_hdr: got %h exp 1008000", tag, {wb_sel, wb_adr}); end
    wb_ack = 1'b1; wb_i_dat = 16'hA55A;
    tick();
    wb_ack = 1'b0; wb_i_dat = 16'h0000;
    nchecks++; if ({wb_stb, cw_ack, cw_err, cw_io_o} !== {3'b010, 8'h5A}) begin nerrors++; $display("FAIL %s_b0: got %b/%h exp 010/5a", tag, {wb_stb, cw_ack, cw_err}, cw_io_o); end
    tick();
    nchecks++; if ({cw_ack, cw_err, cw_io_o} !== {2'b00, 8'hA5}) begin nerrors++; $display("FAIL %s_b1: got %b/%h exp 00/a5", tag, {cw_ack, cw_err}, cw_io_o); end
    tick();
    nchecks++; if ({o_busy, cw_ack, cw_io_o} !== 10'd0) begin nerrors++; $display("FAIL %s_end: got %b/%h exp 00/00", tag, {o_busy, cw_ack}, cw_io_o); end
    $display("txn read %s adr=008000 sel=1 rdat=a55a", tag);
  endtask

  task automatic test_read;
    read_a55a("rd");
  endtask

  task automatic test_error;
    beat(1, 0, 8'h10); beat(0, 0, 8'h00); beat(0, 0, 8'h00); beat(0, 0, 8'h02);
    wb_ack = 1'b1; wb_err = 1'b1; wb_i_dat = 16'hFFFF;
    tick();
    wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = 16'h0000;
    nchecks++; if ({wb_cyc, cw_ack, cw_err, cw_io_o} !== {3'b001, 8'h00}) begin nerrors++; $display("FAIL err_resp: got %b/%h exp 001/00", {wb_cyc, cw_ack, cw_err}, cw_io_o); end
    tick();
    nchecks++; if ({cw_ack, cw_err, o_busy, cw_io_o} !== 11'd0) begin nerrors++; $display("FAIL err_end: got %b/%h exp 000/00", {cw_ack, cw_err, o_busy}, cw_io_o); end
    $display("txn read adr=000010 slave ack+err -> cw_err");
  endtask

  task automatic test_back_to_back;
    int starts0;
    read_a55a("b2b_a");
    starts0 = stb_starts;
    // Header of the second read is issued in the first IDLE cycle.
    beat(1, 0, 8'h00); beat(0, 0, 8'h80); beat(0, 0, 8'h00); beat(0, 0, 8'h01);
    nchecks++; if ({wb_stb, wb_adr} !== {1'b1, 24'h008000}) begin nerrors++; $display("FAIL b2b_stb: got %b/%h exp 1/008000", wb_stb, wb_adr); end
    beat(1, 1, 8'h77);
    wb_ack = 1'b1; wb_i_dat = 16'h1234;
    tick();
    wb_ack = 1'b0;
    nchecks++; if ({cw_ack, cw_io_o} !== {1'b1, 8'h34}) begin nerrors++; $display("FAIL b2b_b0: got %b/%h exp 1/34", cw_ack, cw_io_o); end
    tick(); tick(); tick(); tick();
    nchecks++; if (stb_starts - starts0 !== 1) begin nerrors++; $display("FAIL b2b_ncyc: got %0d exp 1", stb_starts - starts0); end
    nchecks++; if ({o_busy, wb_cyc} !== 2'b00) begin nerrors++; $display("FAIL b2b_idle: got %b exp 00", {o_busy, wb_cyc}); end
    $display("txn back-to-back read, ignored req in WB");
  endtask

  task automatic test_reset_mid;
    int starts0 = stb_starts;
    beat(1, 1, 8'h78); beat(0, 0, 8'h56); beat(0, 0, 8'h34); beat(0, 0, 8'h02); beat(0, 0, 8'h11);
    #2 rst = 1'b1;
    #1;
    nchecks++; if ({o_busy, wb_cyc, cw_ack, cw_err} !== 4'b0) begin nerrors++; $display("FAIL rmid_out: got %b exp 0000", {o_busy, wb_cyc, cw_ack, cw_err}); end
    tick();
    rst = 1'b0;
    tick(); tick();
    nchecks++; if (stb_starts - starts0 !== 0) begin nerrors++; $display("FAIL rmid_ncyc: got %0d exp 0", stb_starts - starts0); end
    beat(1, 1, 8'hCD); beat(0, 0, 8'hAB); beat(0, 0, 8'h00); beat(0, 0, 8'h01); beat(0, 0, 8'h22); beat(0, 0, 8'h11);
    nchecks++; if ({wb_stb, wb_we, wb_sel, wb_adr, wb_o_dat} !== {2'b11, 2'd1, 24'h00ABCD, 16'h1122}) begin nerrors++; $display("FAIL rmid_wb: got %b/%h/%h/%h exp 11/1/00abcd/1122", {wb_stb, wb_we}, wb_sel, wb_adr, wb_o_dat); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    nchecks++; if ({cw_ack, cw_err} !== 2'b10) begin nerrors++; $display("FAIL rmid_ack: got %b exp 10", {cw_ack, cw_err}); end
    tick();
    $display("txn reset mid-WDAT then write adr=00abcd dat=1122");
  endtask

  task automatic test_timeout;
    beat(1, 0, 8'h44); beat(0, 0, 8'h00); beat(0, 0, 8'h00); beat(0, 0, 8'h00);
`ifdef WB_DECOMP_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      nchecks++; if ({wb_stb, cw_err} !== 2'b10) begin nerrors++; $display("FAIL to_stb%0d: got %b exp 10", i, {wb_stb, cw_err}); end
      tick();
    end
    nchecks++; if ({wb_stb, cw_ack, cw_err} !== 3'b001) begin nerrors++; $display("FAIL to_err: got %b exp 001", {wb_stb, cw_ack, cw_err}); end
    tick();
    nchecks++; if ({cw_err, o_busy} !== 2'b00) begin nerrors++; $display("FAIL to_end: got %b exp 00", {cw_err, o_busy}); end
    $display("txn read adr=000044 timeout -> cw_err");
`else
    for (int i = 0; i < 20; i++) tick();
    nchecks++; if ({wb_stb, cw_err, o_busy} !== 3'b101) begin nerrors++; $display("FAIL to_hold: got %b exp 101", {wb_stb, cw_err, o_busy}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    nchecks++; if ({wb_stb, o_busy} !== 2'b00) begin nerrors++; $display("FAIL to_abort: got %b exp 00", {wb_stb, o_busy}); end
    $display("txn read adr=000044 no answer, stb held, aborted by reset");
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
